etapa_mem: RTL and testbench

Memory-access stage of the 64-bit pipeline. It consumes the EX/MEM register outputs, performs doubleword loads and stores against the data memory over a request/grant/response handshake, and stalls the upstream stages while a transaction is outstanding. It delivers registered results to the MEM/WB boundary, inserting bubbles during stalls. It flags misaligned accesses and memory timeouts.

---
 rtl/etapa_mem.sv | 175 +++++++++++++++++
 tb/tb_etapa_mem.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/etapa_mem.sv
// Memory-access pipeline stage: doubleword loads and stores over a request/grant/response
// handshake, with upstream stall, misalignment detection and transaction timeout.
module etapa_mem #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  // EX/MEM register contents
  input  logic        MemWrite_in,
  input  logic        MemtoReg_in,
  input  logic        RegWrite_in,
  input  logic [63:0] ALU_Result_in,
  input  logic [63:0] wr_data_in,
  input  logic [4:0]  dir_rd_in,
  output logic        stall_out,
  // data memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  // MEM/WB boundary
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [63:0] ALU_Result_out,
  output logic [63:0] read_data_out,
  output logic [4:0]  dir_rd_out,
  output logic        err_misaligned_out,
  output logic        err_timeout_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;

  // Fields of the instruction held while its transaction is outstanding
  logic [4:0]  lat_rd;
  logic        lat_regwrite;
  logic        lat_memtoreg;

  logic        mem_op;
  logic        misaligned;
  logic        latch_en;
  logic        complete;

  logic        wb_regwrite;
  logic        wb_memtoreg;
  logic [63:0] wb_alu;
  logic [63:0] wb_rdata;
  logic [4:0]  wb_rd;
  logic        wb_err_mis;
  logic        wb_err_tmo;

  assign mem_op     = MemWrite_in | MemtoReg_in;
  assign misaligned = mem_op & (ALU_Result_in[2:0] != 3'b000);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    stall_out   = 1'b0;
    latch_en    = 1'b0;
    complete    = 1'b0;
    wb_regwrite = 1'b0;
    wb_memtoreg = 1'b0;
    wb_alu      = 64'd0;
    wb_rdata    = 64'd0;
    wb_rd       = 5'd0;
    wb_err_mis  = 1'b0;
    wb_err_tmo  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!mem_op) begin
          wb_regwrite = RegWrite_in;
          wb_memtoreg = MemtoReg_in;
          wb_alu      = ALU_Result_in;
          wb_rd       = dir_rd_in;
        end else if (misaligned) begin
          wb_alu      = ALU_Result_in;
          wb_rd       = dir_rd_in;
          wb_err_mis  = 1'b1;
        end else begin
          latch_en    = 1'b1;
          state_next  = REQ;
          cnt_next    = 8'd0;
          stall_out   = 1'b1;
        end
      end

      REQ, RESP: begin
        if (state_reg == REQ) begin
          if (mem_gnt) begin
            if (mem_we) complete = 1'b1;
            else        state_next = RESP;
          end
        end else begin
          complete = mem_rvalid;
        end

        if (complete) begin
          state_next  = IDLE;
          wb_regwrite = lat_regwrite;
          wb_memtoreg = lat_memtoreg;
          wb_alu      = mem_addr;
          wb_rd       = lat_rd;
          wb_rdata    = mem_we ? 64'd0 : mem_rdata;
        end else if (cnt_reg == CNT_LAST) begin
          // Abort: the instruction is dropped and EX/MEM is released
          state_next  = IDLE;
          wb_err_tmo  = 1'b1;
        end else begin
          cnt_next    = cnt_reg + 8'd1;
          stall_out   = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      cnt_reg            <= 8'd0;
      lat_rd             <= 5'd0;
      lat_regwrite       <= 1'b0;
      lat_memtoreg       <= 1'b0;
      mem_req            <= 1'b0;
      mem_we             <= 1'b0;
      mem_addr           <= 64'd0;
      mem_wdata          <= 64'd0;
      RegWrite_out       <= 1'b0;
      MemtoReg_out       <= 1'b0;
      ALU_Result_out     <= 64'd0;
      read_data_out      <= 64'd0;
      dir_rd_out         <= 5'd0;
      err_misaligned_out <= 1'b0;
      err_timeout_out    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mem_req   <= (state_next == REQ);

      if (latch_en) begin
        // Store takes priority when both MemWrite and MemtoReg are set
        mem_we       <= MemWrite_in;
        mem_addr     <= ALU_Result_in;
        mem_wdata    <= wr_data_in;
        lat_rd       <= dir_rd_in;
        lat_regwrite <= RegWrite_in;
        lat_memtoreg <= MemtoReg_in;
      end

      RegWrite_out       <= wb_regwrite;
      MemtoReg_out       <= wb_memtoreg;
      ALU_Result_out     <= wb_alu;
      read_data_out      <= wb_rdata;
      dir_rd_out         <= wb_rd;
      err_misaligned_out <= wb_err_mis;
      err_timeout_out    <= wb_err_tmo;
    end
  end

endmodule

// File: tb/tb_etapa_mem.sv
// Self-checking bench for etapa_mem: transaction-level reference model with randomized
// handshake delays and directed boundary cases (timeout limit, reset mid-transaction).
module tb_etapa_mem;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWrite_in, MemtoReg_in, RegWrite_in;
  logic [63:0] ALU_Result_in, wr_data_in;
  logic [4:0]  dir_rd_in;
  logic        stall_out;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [63:0] mem_rdata;
  logic        RegWrite_out, MemtoReg_out;
  logic [63:0] ALU_Result_out, read_data_out;
  logic [4:0]  dir_rd_out;
  logic        err_misaligned_out, err_timeout_out;

  int checks = 0;
  int errors = 0;

  etapa_mem #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .MemWrite_in(MemWrite_in), .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
    .ALU_Result_in(ALU_Result_in), .wr_data_in(wr_data_in), .dir_rd_in(dir_rd_in),
    .stall_out(stall_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .ALU_Result_out(ALU_Result_out), .read_data_out(read_data_out), .dir_rd_out(dir_rd_out),
    .err_misaligned_out(err_misaligned_out), .err_timeout_out(err_timeout_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, summary forced");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    MemWrite_in   = 1'b0;
    MemtoReg_in   = 1'b0;
    RegWrite_in   = 1'b0;
    ALU_Result_in = 64'd0;
    wr_data_in    = 64'd0;
    dir_rd_in     = 5'd0;
    mem_gnt       = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = 64'd0;
  endtask

  // kind: 0 = ALU, 1 = store, 2 = load. g = wait cycles before gnt, r = wait cycles
  // between gnt and rvalid. Instruction is presented at k=0 and held until stall drops.
  task automatic run_instr(input int kind, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [4:0] rd, input logic rw, input int g, input int r,
                           input logic [63:0] rdata, input string tag);
    bit is_mem, is_store, is_load, mis, done;
    int e, req_last;
    logic exp_rw, exp_mtr, exp_emis, exp_etmo, chk_data;
    logic [63:0] exp_rdata;

    is_mem   = (kind != 0);
    is_store = (kind == 1);
    is_load  = (kind == 2);
    mis      = is_mem && (addr[2:0] != 3'b000);
    if (!is_mem || mis) begin
      done = 1'b1; e = 0;
    end else if (is_store) begin
      done = (g <= T - 1); e = done ? 1 + g : T;
    end else begin
      done = (g + r + 2 <= T); e = done ? 2 + g + r : T;
    end
    req_last = (is_mem && !mis) ? 1 + ((g < T - 1) ? g : T - 1) : 0;

    for (int k = 0; k <= e; k++) begin
      MemWrite_in   = is_store;
      MemtoReg_in   = is_load;
      RegWrite_in   = rw;
      ALU_Result_in = addr;
      wr_data_in    = wdata;
      dir_rd_in     = rd;
      if (k == 1 + g)                mem_gnt = 1'b1;
      else if (k == 0 || k > 1 + g)  mem_gnt = 1'($urandom_range(0, 1));
      else                           mem_gnt = 1'b0;
      if (is_load && k == 2 + g + r) begin
        mem_rvalid = 1'b1; mem_rdata = rdata;
      end else begin
        mem_rvalid = (k <= 1 + g) ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata  = {$urandom, $urandom};
      end
      #1;
      checks++;
      if (stall_out !== (k < e)) begin
        errors++;
        $display("FAIL %s stall k=%0d: got %b expected %b", tag, k, stall_out, (k < e));
      end
      checks++;
      if (mem_req !== (k >= 1 && k <= req_last)) begin
        errors++;
        $display("FAIL %s mem_req k=%0d: got %b expected %b", tag, k, mem_req,
                 (k >= 1 && k <= req_last));
      end
      if (k >= 1 && k <= req_last) begin
        checks++;
        if (mem_we !== is_store || mem_addr !== addr || (is_store && mem_wdata !== wdata)) begin
          errors++;
          $display("FAIL %s mem_port k=%0d: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                   tag, k, mem_we, mem_addr, mem_wdata, is_store, addr, wdata);
        end
      end
      if (k >= 1) begin
        checks++;
        if (RegWrite_out !== 1'b0 || MemtoReg_out !== 1'b0 ||
            err_misaligned_out !== 1'b0 || err_timeout_out !== 1'b0) begin
          errors++;
          $display("FAIL %s bubble k=%0d: got rw=%b mtr=%b emis=%b etmo=%b expected all 0",
                   tag, k, RegWrite_out, MemtoReg_out, err_misaligned_out, err_timeout_out);
        end
      end
      tick();
    end
    drive_nop();

    exp_rdata = 64'd0;
    chk_data  = 1'b0;
    exp_emis  = 1'b0;
    exp_etmo  = 1'b0;
    exp_rw    = 1'b0;
    exp_mtr   = 1'b0;
    if (!is_mem) begin
      exp_rw = rw; chk_data = 1'b1;
    end else if (mis) begin
      exp_emis = 1'b1;
    end else if (done) begin
      exp_rw = rw; exp_mtr = is_load; chk_data = 1'b1;
      exp_rdata = is_load ? rdata : 64'd0;
    end else begin
      exp_etmo = 1'b1;
    end

    checks++;
    if (RegWrite_out !== exp_rw || MemtoReg_out !== exp_mtr ||
        err_misaligned_out !== exp_emis || err_timeout_out !== exp_etmo || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s ctrl: got rw=%b mtr=%b emis=%b etmo=%b req=%b expected rw=%b mtr=%b emis=%b etmo=%b req=0",
               tag, RegWrite_out, MemtoReg_out, err_misaligned_out, err_timeout_out, mem_req,
               exp_rw, exp_mtr, exp_emis, exp_etmo);
    end
    if (chk_data || mis) begin
      checks++;
      if (dir_rd_out !== rd) begin
        errors++;
        $display("FAIL %s rd: got %0d expected %0d", tag, dir_rd_out, rd);
      end
    end
    if (chk_data) begin
      checks++;
      if (ALU_Result_out !== addr || read_data_out !== exp_rdata) begin
        errors++;
        $display("FAIL %s data: got alu=%h rdata=%h expected alu=%h rdata=%h",
                 tag, ALU_Result_out, read_data_out, addr, exp_rdata);
      end
    end
    $display("txn %s kind=%0d addr=%h g=%0d r=%0d cycles=%0d done=%0d mis=%0d",
             tag, kind, addr, g, r, e + 1, done, mis);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_nop();
    tick();
    tick();
    checks++;
    if (RegWrite_out !== 1'b0 || MemtoReg_out !== 1'b0 || ALU_Result_out !== 64'd0 ||
        read_data_out !== 64'd0 || dir_rd_out !== 5'd0 || err_misaligned_out !== 1'b0 ||
        err_timeout_out !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
        mem_addr !== 64'd0 || mem_wdata !== 64'd0 || stall_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rw=%b mtr=%b alu=%h rdata=%h rd=%0d req=%b we=%b addr=%h wdata=%h stall=%b expected all 0",
               RegWrite_out, MemtoReg_out, ALU_Result_out, read_data_out, dir_rd_out,
               mem_req, mem_we, mem_addr, mem_wdata, stall_out);
    end
    rst = 1'b0;
    $display("txn reset");
  endtask

  task automatic test_alu();
    run_instr(0, 64'h1234, 64'd0, 5'd5, 1'b1, 0, 0, 64'd0, "alu");
  endtask

  task automatic test_store();
    run_instr(1, 64'h100, 64'hDEADBEEF, 5'd3, 1'b0, 2, 0, 64'd0, "store_wait2");
    run_instr(1, 64'h108, 64'h0123_4567_89AB_CDEF, 5'd4, 1'b0, 0, 0, 64'd0, "store_imm");
  endtask

  task automatic test_load();
    run_instr(2, 64'h200, 64'd0, 5'd7, 1'b1, 0, 2, 64'hCAFE, "load_limit");
    run_instr(2, 64'h208, 64'd0, 5'd8, 1'b1, 0, 0, 64'hFACE_B00C, "load_fast");
  endtask

  task automatic test_misaligned();
    run_instr(2, 64'h203, 64'd0, 5'd9, 1'b1, 0, 0, 64'h1, "load_mis");
    run_instr(1, 64'h30C, 64'h55, 5'd10, 1'b0, 0, 0, 64'h0, "store_mis");
  endtask

  task automatic test_timeout();
    run_instr(2, 64'h400, 64'd0, 5'd11, 1'b1, 1000, 0, 64'h0, "load_no_gnt");
    run_instr(2, 64'h408, 64'd0, 5'd12, 1'b1, 0, 3, 64'hBAD, "load_late_rvalid");
    run_instr(1, 64'h410, 64'h77, 5'd13, 1'b0, T, 0, 64'h0, "store_late_gnt");
    // A response arriving after the abort must be discarded
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 64'hBEEF;
      tick();
      checks++;
      if (read_data_out !== 64'd0 || MemtoReg_out !== 1'b0 || mem_req !== 1'b0 ||
          err_timeout_out !== 1'b0) begin
        errors++;
        $display("FAIL stale_rvalid %0d: got rdata=%h mtr=%b req=%b etmo=%b expected 0 0 0 0",
                 i, read_data_out, MemtoReg_out, mem_req, err_timeout_out);
      end
    end
    drive_nop();
    $display("txn stale_rvalid ignored");
  endtask

  task automatic test_reset_mid();
    MemtoReg_in   = 1'b1;
    RegWrite_in   = 1'b1;
    ALU_Result_in = 64'h300;
    dir_rd_in     = 5'd14;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (RegWrite_out !== 1'b0 || MemtoReg_out !== 1'b0 || ALU_Result_out !== 64'd0 ||
        read_data_out !== 64'd0 || dir_rd_out !== 5'd0 || mem_req !== 1'b0 ||
        mem_addr !== 64'd0 || err_timeout_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got rw=%b mtr=%b alu=%h rdata=%h rd=%0d req=%b addr=%h etmo=%b expected all 0",
               RegWrite_out, MemtoReg_out, ALU_Result_out, read_data_out, dir_rd_out,
               mem_req, mem_addr, err_timeout_out);
    end
    drive_nop();
    RegWrite_in   = 1'b1;
    ALU_Result_in = 64'h55;
    dir_rd_in     = 5'd9;
    mem_rvalid    = 1'b1;
    mem_rdata     = 64'hDEAD;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stall: got %b expected 0", stall_out);
    end
    tick();
    drive_nop();
    checks++;
    if (RegWrite_out !== 1'b1 || ALU_Result_out !== 64'h55 || dir_rd_out !== 5'd9 ||
        read_data_out !== 64'd0 || MemtoReg_out !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_alu: got rw=%b alu=%h rd=%0d rdata=%h mtr=%b req=%b expected 1 55 9 0 0 0",
               RegWrite_out, ALU_Result_out, dir_rd_out, read_data_out, MemtoReg_out, mem_req);
    end
    $display("txn reset_mid_transaction");
  endtask

  task automatic test_back_to_back();
    run_instr(0, 64'hA1, 64'd0, 5'd1, 1'b1, 0, 0, 64'd0, "b2b_alu0");
    run_instr(0, 64'hA2, 64'd0, 5'd2, 1'b0, 0, 0, 64'd0, "b2b_alu1");
    run_instr(1, 64'hA8, 64'h99, 5'd3, 1'b0, 1, 0, 64'd0, "b2b_store");
    run_instr(2, 64'hB0, 64'd0, 5'd4, 1'b1, 1, 1, 64'h1357, "b2b_load");
    run_instr(0, 64'hA3, 64'd0, 5'd5, 1'b1, 0, 0, 64'd0, "b2b_alu2");
  endtask

  task automatic test_random();
    int kind, g, r;
    logic [63:0] addr;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      addr = {$urandom, $urandom};
      if (kind != 0 && $urandom_range(0, 5) != 0) addr[2:0] = 3'b000;
      g = $urandom_range(0, 4);
      r = $urandom_range(0, 3);
      run_instr(kind, addr, {$urandom, $urandom}, 5'($urandom), 1'($urandom),
                g, r, {$urandom, $urandom}, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
